// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB3 requester with PREADY timeout
module apb_master_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16,
    parameter int TO_CNT_W   = 8
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic                    lat_write;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [TO_CNT_W-1:0]     to_cnt;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic                    timeout_q;
    logic                    timeout_hit;

    // Current wait cycle is the TIMEOUT-th consecutive one without pready.
    assign timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        psel        = 1'b0;
        penable     = 1'b0;
        pwrite      = 1'b0;
        paddr       = '0;
        pwdata      = '0;
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        rsp_err     = 1'b0;
        rsp_timeout = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP, ACCESS: begin
                psel    = 1'b1;
                penable = (state == ACCESS);
                pwrite  = lat_write;
                paddr   = lat_addr;
                pwdata  = lat_write ? lat_wdata : '0;
                if (state == SETUP) begin
                    state_nxt = ACCESS;
                end else if (pready || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid   = 1'b1;
                rsp_rdata   = rdata_q;
                rsp_err     = err_q;
                rsp_timeout = timeout_q;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            to_cnt    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                lat_write <= cmd_write;
                lat_addr  <= cmd_addr;
                lat_wdata <= cmd_wdata;
                to_cnt    <= '0;
            end
            if (state == ACCESS) begin
                if (pready) begin
                    rdata_q   <= lat_write ? '0 : prdata;
                    err_q     <= pslverr;
                    timeout_q <= 1'b0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                    if (timeout_hit) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
